pdm_uart_streamer: RTL and testbench
====================================

PDM_UART_STREAMER -- requirements
Module: pdm_uart_streamer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CHANNELS, 2, number of PDM inputs (1..4).
- WORD_BITS, 8, PDM samples packed per channel per frame (8, 16, 24 or 32).
- HEX_MODE, 1, 1 = ASCII hex framing, 0 = raw binary framing.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable.
- pdm_sample  in  1  one-cycle sample strobe.
- pdm_data  in  CHANNELS  one PDM bit per channel.
- clear_ovf  in  1  clears the overflow flag.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmit.
- new_tx_data  out  1  one-cycle transmit request.
- overflow  out  1  sticky frame-drop flag.
- busy  out  1  printer not IDLE, or holding buffer valid.

Function
REQ-003 On each clk with enable=1 and pdm_sample=1, each channel SHALL shift pdm_data[ch] in MSB-first, so the first sample ends up in the word MSB; the sample counter increments.
REQ-004 A frame SHALL complete on the strobe where the counter reaches WORD_BITS-1; the counter then wraps to 0.
REQ-005 On completion, all channel words SHALL load the holding buffer and set hold_valid on the next cycle, unless hold_valid=1 and is not being cleared in the same cycle.
REQ-006 If a frame completes while hold_valid=1 and is not being cleared in that cycle, the frame SHALL be dropped and overflow set to 1 on the next cycle.
REQ-007 A completion coinciding with the printer clearing hold_valid SHALL be accepted, not dropped.
REQ-008 overflow SHALL stay 1 until clear_ovf=1. If clear_ovf and a new drop occur in the same cycle, overflow SHALL be 1.
REQ-009 enable=0 SHALL clear the sample counter and shift registers. Partial frames SHALL be discarded; the holding buffer and printer SHALL be unaffected.
REQ-010 Printer FSM states SHALL be IDLE, HEADER, DATA and TRAILER.
- IDLE: if hold_valid, copy the buffer to the print register, clear hold_valid, go to HEADER.
- HEADER -> DATA -> TRAILER (HEX_MODE=1) or -> IDLE (HEX_MODE=0); TRAILER -> IDLE.
REQ-011 Header byte SHALL be 0x50 ('P') when HEX_MODE=1 and 0xA5 when HEX_MODE=0.
REQ-012 DATA, HEX_MODE=1: channels SHALL be sent in order 0..CHANNELS-1.
- WORD_BITS/4 uppercase ASCII hex characters per channel, MSB nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
REQ-013 DATA, HEX_MODE=0: WORD_BITS/8 bytes per channel, MSB byte first.
REQ-014 TRAILER SHALL send 0x0D then 0x0A.
REQ-015 A byte SHALL be issued by driving tx_data and new_tx_data=1 (registered) for exactly one cycle, only when tx_busy=0 and new_tx_data was 0 in the previous cycle. The minimum spacing between pulses is 2 cycles.
REQ-016 tx_data SHALL hold its last value when new_tx_data=0. No byte SHALL be skipped or repeated, regardless of how long tx_busy stays high.
REQ-017 Latency: a frame completing in cycle N, with the printer IDLE and tx_busy=0, SHALL give the header pulse in cycle N+2.
REQ-018 Byte-index and channel counters SHALL wrap to 0 at frame end.

Reset
REQ-019 rst=1 SHALL immediately set the following, independent of clk:
- tx_data=0x00, new_tx_data=0, overflow=0, busy=0.
- FSM=IDLE; hold_valid=0; all counters and shift registers 0.
REQ-020 Reset mid-frame SHALL abandon the frame. The first byte after release SHALL be a header of a frame captured entirely after release.

Structure
REQ-021 Package pdm_uart_pkg SHALL hold the FSM state type, the header constants 0x50 and 0xA5, the CR/LF constants and the nibble-to-ASCII function.
REQ-022 Capture (shift registers, counter, holding buffer, overflow) SHALL be sub-module pdm_frame_capture. The printer FSM SHALL stay in pdm_uart_streamer.

Verification
REQ-023 All scenarios use CHANNELS=2, WORD_BITS=8, tx_busy=0 unless stated.
- HEX_MODE=1, ch0 samples 1,0,1,0,0,1,0,1 and ch1 samples 0,0,1,1,1,1,0,0 -> bytes 0x50,0x41,0x35,0x33,0x43,0x0D,0x0A.
- HEX_MODE=0, same stimulus -> bytes 0xA5,0xA5,0x3C; header pulse exactly 2 cycles after the 8th strobe.
- tx_busy high for 20 cycles mid-frame -> no pulses while high; the remaining bytes then follow in order, none lost or repeated.
- tx_busy held high across 3 frame completions -> frames 1 and 2 printed, frame 3 dropped, overflow=1 until a clear_ovf pulse.
- rst asserted during the DATA state -> new_tx_data=0 and overflow=0 with no clk edge; after release the next byte is a header.
- enable dropped after 5 strobes, then re-enabled with 8 strobes -> a single frame containing only the last 8 samples.

Source files
------------

// File: rtl/pdm_uart_pkg.sv
// Shared types and constants for the PDM-to-UART streamer.
package pdm_uart_pkg;

    typedef enum logic [1:0] {StIdle, StHeader, StData, StTrailer} print_state_e;

    localparam logic [7:0] HDR_HEX  = 8'h50;  // 'P'
    localparam logic [7:0] HDR_BIN  = 8'hA5;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/pdm_frame_capture.sv
// Deserialises PDM bits into per-channel words and hands complete frames
// to a single-entry holding buffer; drops and flags frames when it is full.
module pdm_frame_capture #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WORD_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          pdm_sample,
    input  logic [CHANNELS-1:0]           pdm_data,
    input  logic                          clear_ovf,
    input  logic                          hold_clear,
    output logic [CHANNELS*WORD_BITS-1:0] hold_data,
    output logic                          hold_valid,
    output logic                          overflow
);
    localparam int unsigned FW    = CHANNELS * WORD_BITS;
    localparam int unsigned CNT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    shift_q, shift_d, shifted;
    logic             frame_done, accept, drop;

    // Next shift-register contents with the current bit appended at the LSB.
    always_comb begin
        shifted = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            shifted[ch*WORD_BITS +: WORD_BITS] =
                {shift_q[ch*WORD_BITS +: WORD_BITS-1], pdm_data[ch]};
        end
    end

    // A frame is accepted if the buffer is empty or being drained this cycle.
    always_comb begin
        frame_done = enable && pdm_sample && (cnt_q == LAST_CNT);
        accept     = frame_done && (!hold_valid || hold_clear);
        drop       = frame_done && !accept;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        if (!enable) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (pdm_sample) begin
            shift_d = shifted;
            cnt_d   = frame_done ? '0 : cnt_q + 1'b1;
        end
    end

    // Capture state, holding buffer and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            if (accept) begin
                hold_data  <= shifted;
                hold_valid <= 1'b1;
            end else if (hold_clear) begin
                hold_valid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pdm_uart_streamer.sv
// Captures multi-channel PDM frames and prints each one as a framed byte
// stream (ASCII hex or raw binary) through a UART transmitter handshake.
module pdm_uart_streamer #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned HEX_MODE  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pdm_sample,
    input  logic [CHANNELS-1:0] pdm_data,
    input  logic                clear_ovf,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    output logic                overflow,
    output logic                busy
);
    import pdm_uart_pkg::*;

    localparam int unsigned FW    = CHANNELS * WORD_BITS;
    localparam int unsigned UNITS = (HEX_MODE != 0) ? WORD_BITS / 4 : WORD_BITS / 8;
    localparam logic [2:0]  LAST_IDX = 3'(UNITS - 1);
    localparam logic [1:0]  LAST_CH  = 2'(CHANNELS - 1);
    localparam logic [7:0]  HDR      = (HEX_MODE != 0) ? HDR_HEX : HDR_BIN;

    print_state_e state_q, state_d;
    logic [FW-1:0] hold_data, print_q, print_d;
    logic          hold_valid, hold_clear;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    ch_q, ch_d;
    logic [7:0]    tx_data_d, data_byte;
    logic          new_tx_data_d, can_send;

    pdm_frame_capture #(
        .CHANNELS (CHANNELS),
        .WORD_BITS(WORD_BITS)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pdm_sample(pdm_sample),
        .pdm_data  (pdm_data),
        .clear_ovf (clear_ovf),
        .hold_clear(hold_clear),
        .hold_data (hold_data),
        .hold_valid(hold_valid),
        .overflow  (overflow)
    );

    assign busy     = (state_q != StIdle) || hold_valid;
    // Registered pulse forces at least one idle cycle between bytes.
    assign can_send = !tx_busy && !new_tx_data;

    // Select the current data byte: a hex digit or a raw byte, MSB first.
    always_comb begin
        int base;
        base      = 0;
        data_byte = '0;
        if (HEX_MODE != 0) begin
            base      = int'(ch_q) * int'(WORD_BITS) + int'(WORD_BITS) - 4 - 4 * int'(idx_q);
            data_byte = nib_to_ascii(print_q[base +: 4]);
        end else begin
            base      = int'(ch_q) * int'(WORD_BITS) + int'(WORD_BITS) - 8 - 8 * int'(idx_q);
            data_byte = print_q[base +: 8];
        end
    end

    // Printer next-state and byte issue.
    always_comb begin
        state_d       = state_q;
        print_d       = print_q;
        idx_d         = idx_q;
        ch_d          = ch_q;
        tx_data_d     = tx_data;
        new_tx_data_d = 1'b0;
        hold_clear    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold_valid) begin
                    print_d    = hold_data;
                    hold_clear = 1'b1;
                    // Header goes out in the same step when possible to save a cycle.
                    if (can_send) begin
                        tx_data_d     = HDR;
                        new_tx_data_d = 1'b1;
                        state_d       = StData;
                    end else begin
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                if (can_send) begin
                    tx_data_d     = HDR;
                    new_tx_data_d = 1'b1;
                    state_d       = StData;
                end
            end
            StData: begin
                if (can_send) begin
                    tx_data_d     = data_byte;
                    new_tx_data_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (ch_q == LAST_CH) begin
                            ch_d    = '0;
                            state_d = (HEX_MODE != 0) ? StTrailer : StIdle;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StTrailer: begin
                if (can_send) begin
                    tx_data_d     = (idx_q == 3'd0) ? ASCII_CR : ASCII_LF;
                    new_tx_data_d = 1'b1;
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd1;
                    end else begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Printer state register and registered UART outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            print_q     <= '0;
            idx_q       <= '0;
            ch_q        <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
        end else begin
            state_q     <= state_d;
            print_q     <= print_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            tx_data     <= tx_data_d;
            new_tx_data <= new_tx_data_d;
        end
    end

endmodule

// File: tb/tb_pdm_uart_streamer.sv
// Bench for pdm_uart_streamer: a hex-mode and a binary-mode instance share
// stimulus; each has its own expected-byte queue checked by a monitor.
module tb_pdm_uart_streamer;

    logic       clk = 1'b0;
    logic       rst, enable, pdm_sample, clear_ovf, tx_busy;
    logic [1:0] pdm_data;
    logic [7:0] hx_tx, bn_tx;
    logic       hx_new, hx_ovf, hx_busy, bn_new, bn_ovf, bn_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] q_hex[$];
    logic [7:0] q_bin[$];
    logic [8:0] hx_exp, bn_exp;
    logic       hx_prev = 1'b0;
    logic       bn_prev = 1'b0;

    always #5 clk = ~clk;

    pdm_uart_streamer #(.CHANNELS(2), .WORD_BITS(8), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst(rst), .enable(enable), .pdm_sample(pdm_sample),
        .pdm_data(pdm_data), .clear_ovf(clear_ovf), .tx_busy(tx_busy),
        .tx_data(hx_tx), .new_tx_data(hx_new), .overflow(hx_ovf), .busy(hx_busy)
    );

    pdm_uart_streamer #(.CHANNELS(2), .WORD_BITS(8), .HEX_MODE(0)) dut_bin (
        .clk(clk), .rst(rst), .enable(enable), .pdm_sample(pdm_sample),
        .pdm_data(pdm_data), .clear_ovf(clear_ovf), .tx_busy(tx_busy),
        .tx_data(bn_tx), .new_tx_data(bn_new), .overflow(bn_ovf), .busy(bn_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1);
        q_hex.push_back(8'h50);
        q_hex.push_back(hex_char(w0[7:4]));
        q_hex.push_back(hex_char(w0[3:0]));
        q_hex.push_back(hex_char(w1[7:4]));
        q_hex.push_back(hex_char(w1[3:0]));
        q_hex.push_back(8'h0D);
        q_hex.push_back(8'h0A);
        q_bin.push_back(8'hA5);
        q_bin.push_back(w0);
        q_bin.push_back(w1);
    endtask

    // Sends the n most significant bits of each word, MSB first, one per cycle.
    task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pdm_sample = 1'b1;
            pdm_data   = {w1[7-i], w0[7-i]};
        end
        @(negedge clk);
        pdm_sample = 1'b0;
        pdm_data   = 2'b00;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_hex.size() != 0 || q_bin.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_left", q_hex.size() + q_bin.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_hex_pulses(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (hx_new) seen++;
        end
        check_eq("pulse_wait", seen, n);
    endtask

    // Hex-instance monitor: pops and compares each issued byte.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            hx_prev = 1'b0;
        end else begin
            if (hx_new) begin
                hx_exp = (q_hex.size() != 0) ? {1'b0, q_hex.pop_front()} : 9'h100;
                check_eq("hex_byte", {1'b0, hx_tx}, hx_exp);
                check_eq("hex_tx_busy", tx_busy, 0);
                check_eq("hex_spacing", hx_prev, 0);
            end
            hx_prev = hx_new;
        end
    end

    // Binary-instance monitor.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bn_prev = 1'b0;
        end else begin
            if (bn_new) begin
                bn_exp = (q_bin.size() != 0) ? {1'b0, q_bin.pop_front()} : 9'h100;
                check_eq("bin_byte", {1'b0, bn_tx}, bn_exp);
                check_eq("bin_tx_busy", tx_busy, 0);
                check_eq("bin_spacing", bn_prev, 0);
            end
            bn_prev = bn_new;
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b0; pdm_sample = 1'b0; pdm_data = 2'b00;
        clear_ovf = 1'b0; tx_busy = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_hex_tx", hx_tx, 8'h00);
        check_eq("rst_hex_new", hx_new, 0);
        check_eq("rst_hex_ovf", hx_ovf, 0);
        check_eq("rst_hex_busy", hx_busy, 0);
        check_eq("rst_bin_tx", bn_tx, 8'h00);
        check_eq("rst_bin_busy", bn_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Reference frame and header latency.
        push_frame(8'hA5, 8'h3C);
        send_bits(8'hA5, 8'h3C, 8);
        check_eq("lat_early_hex", hx_new, 0);
        check_eq("lat_early_bin", bn_new, 0);
        @(posedge clk);
        #1;
        check_eq("lat_bin_new", bn_new, 1);
        check_eq("lat_bin_hdr", bn_tx, 8'hA5);
        check_eq("lat_hex_new", hx_new, 1);
        wait_drain();

        // Transmitter stall in the middle of a frame.
        push_frame(8'h5A, 8'hC3);
        send_bits(8'h5A, 8'hC3, 8);
        wait_hex_pulses(3);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("stall_busy", hx_busy, 1);
        tx_busy = 1'b0;
        wait_drain();

        // Three frames while stalled: third is dropped.
        tx_busy = 1'b1;
        push_frame(8'h12, 8'h34);
        send_bits(8'h12, 8'h34, 8);
        push_frame(8'h9E, 8'hF0);
        send_bits(8'h9E, 8'hF0, 8);
        check_eq("ovf_before_hex", hx_ovf, 0);
        check_eq("ovf_before_bin", bn_ovf, 0);
        send_bits(8'h55, 8'h66, 8);
        check_eq("ovf_set_hex", hx_ovf, 1);
        check_eq("ovf_set_bin", bn_ovf, 1);
        tx_busy = 1'b0;
        wait_drain();
        check_eq("ovf_sticky_hex", hx_ovf, 1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check_eq("ovf_clr_hex", hx_ovf, 0);
        check_eq("ovf_clr_bin", bn_ovf, 0);

        // Asynchronous reset while printing data.
        tx_busy = 1'b1;
        push_frame(8'h01, 8'h02);
        send_bits(8'h01, 8'h02, 8);
        push_frame(8'h03, 8'h04);
        send_bits(8'h03, 8'h04, 8);
        send_bits(8'h05, 8'h06, 8);
        check_eq("ovf_again", hx_ovf, 1);
        tx_busy = 1'b0;
        wait_hex_pulses(2);
        rst = 1'b1;
        #1;
        check_eq("arst_hex_new", hx_new, 0);
        check_eq("arst_hex_ovf", hx_ovf, 0);
        check_eq("arst_hex_tx", hx_tx, 8'h00);
        check_eq("arst_hex_busy", hx_busy, 0);
        check_eq("arst_bin_new", bn_new, 0);
        check_eq("arst_bin_ovf", bn_ovf, 0);
        q_hex.delete();
        q_bin.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_idle", hx_busy, 0);
        push_frame(8'hB7, 8'h0F);
        send_bits(8'hB7, 8'h0F, 8);
        wait_drain();

        // Partial frame discarded by enable=0.
        send_bits(8'hFF, 8'hFF, 5);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        push_frame(8'h69, 8'hD2);
        send_bits(8'h69, 8'hD2, 8);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
